// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Define MULDIV_SEQ_DIV_EN to build the divide datapath; otherwise divide opcodes return 0.
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_LENGTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [OP_LENGTH-1:0]  Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     op_q;
  logic [W-1:0]   opnd_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic           neg_q;

  logic           a_signed, b_signed, a_neg, b_neg, ld_neg;
  logic [W-1:0]   a_mag, b_mag, ld_opnd, ld_lo;
  logic [W:0]     sum;
  logic [W-1:0]   step_hi, step_lo, final_res;
  logic [2*W-1:0] prod, prod_s;

  // Operand decode at issue: magnitudes plus the sign to re-apply to the final result.
  always_comb begin
    if (!Operation[2]) begin
      a_signed = (Operation[1:0] != 2'b11);
      b_signed = !Operation[1];
    end else begin
      a_signed = !Operation[0];
      b_signed = !Operation[0];
    end
    a_neg = a_signed & SrcA[W-1];
    b_neg = b_signed & SrcB[W-1];
    a_mag = a_neg ? -SrcA : SrcA;
    b_mag = b_neg ? -SrcB : SrcB;
    if (!Operation[2]) begin
      ld_opnd = a_mag;
      ld_lo   = b_mag;
      ld_neg  = a_neg ^ b_neg;
    end else begin
      ld_opnd = b_mag;
      ld_lo   = a_mag;
      // Divide by zero keeps the all-ones quotient unsigned; remainder follows the dividend.
      ld_neg  = Operation[1] ? a_neg : ((a_neg ^ b_neg) & (|SrcB));
    end
  end

`ifdef MULDIV_SEQ_DIV_EN
  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic [W-1:0] div_sel;
`endif

  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    sum     = '0;
`ifdef MULDIV_SEQ_DIV_EN
    shifted = '0;
    diff    = '0;
`endif
    if (!op_q[2]) begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      step_hi = sum[W:1];
      step_lo = {sum[0], lo_q[W-1:1]};
    end
`ifdef MULDIV_SEQ_DIV_EN
    else begin
      shifted = {hi_q, lo_q[W-1]};
      diff    = {1'b0, shifted} - {2'b00, opnd_q};
      if (!diff[W+1]) begin
        step_hi = diff[W-1:0];
        step_lo = {lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = shifted[W-1:0];
        step_lo = {lo_q[W-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_q ? -prod : prod;
`ifdef MULDIV_SEQ_DIV_EN
    div_sel = op_q[1] ? step_hi : step_lo;
`endif
    if (!op_q[2]) begin
      final_res = (op_q[1:0] == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    end else begin
`ifdef MULDIV_SEQ_DIV_EN
      final_res = neg_q ? -div_sel : div_sel;
`else
      final_res = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !flush) begin
            state  <= StCalc;
            busy   <= 1'b1;
            op_q   <= Operation[2:0];
            opnd_q <= ld_opnd;
            hi_q   <= '0;
            lo_q   <= ld_lo;
            neg_q  <= ld_neg;
            cnt_q  <= '0;
          end
        end
        StCalc: begin
          if (flush) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
              state  <= StDone;
              done   <= 1'b1;
              Result <= final_res;
            end
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
